// File: rtl/tl_inflight_buffer_if.sv
// tl_inflight_buffer_if
//   Groups the TileLink A/D handshakes seen by tl_inflight_buffer.
//   auto_in_*  : upstream side (A arrives here, D leaves here)
//   auto_out_* : downstream side toward the width widget (A leaves, D arrives)
//   Modports:
//     slave  - the buffer itself
//     master - the environment driving upstream A / downstream D
interface tl_inflight_buffer_if;
  logic         auto_in_a_valid;
  logic         auto_in_a_ready;
  logic [2:0]   auto_in_a_bits_opcode;
  logic [2:0]   auto_in_a_bits_size;
  logic [1:0]   auto_in_a_bits_source;
  logic [35:0]  auto_in_a_bits_address;
  logic [31:0]  auto_in_a_bits_mask;
  logic [255:0] auto_in_a_bits_data;

  logic         auto_out_a_valid;
  logic         auto_out_a_ready;
  logic [2:0]   auto_out_a_bits_opcode;
  logic [2:0]   auto_out_a_bits_size;
  logic [1:0]   auto_out_a_bits_source;
  logic [35:0]  auto_out_a_bits_address;
  logic [31:0]  auto_out_a_bits_mask;
  logic [255:0] auto_out_a_bits_data;

  logic         auto_out_d_valid;
  logic         auto_out_d_ready;
  logic [2:0]   auto_out_d_bits_opcode;
  logic [2:0]   auto_out_d_bits_size;
  logic [1:0]   auto_out_d_bits_source;
  logic         auto_out_d_bits_denied;
  logic [255:0] auto_out_d_bits_data;
  logic         auto_out_d_bits_corrupt;

  logic         auto_in_d_valid;
  logic         auto_in_d_ready;
  logic [2:0]   auto_in_d_bits_opcode;
  logic [2:0]   auto_in_d_bits_size;
  logic [1:0]   auto_in_d_bits_source;
  logic         auto_in_d_bits_denied;
  logic [255:0] auto_in_d_bits_data;
  logic         auto_in_d_bits_corrupt;

  modport slave (
    input  auto_in_a_valid, auto_in_a_bits_opcode, auto_in_a_bits_size,
           auto_in_a_bits_source, auto_in_a_bits_address, auto_in_a_bits_mask,
           auto_in_a_bits_data,
    output auto_in_a_ready,
    output auto_out_a_valid, auto_out_a_bits_opcode, auto_out_a_bits_size,
           auto_out_a_bits_source, auto_out_a_bits_address, auto_out_a_bits_mask,
           auto_out_a_bits_data,
    input  auto_out_a_ready,
    input  auto_out_d_valid, auto_out_d_bits_opcode, auto_out_d_bits_size,
           auto_out_d_bits_source, auto_out_d_bits_denied, auto_out_d_bits_data,
           auto_out_d_bits_corrupt,
    output auto_out_d_ready,
    output auto_in_d_valid, auto_in_d_bits_opcode, auto_in_d_bits_size,
           auto_in_d_bits_source, auto_in_d_bits_denied, auto_in_d_bits_data,
           auto_in_d_bits_corrupt,
    input  auto_in_d_ready
  );

  modport master (
    output auto_in_a_valid, auto_in_a_bits_opcode, auto_in_a_bits_size,
           auto_in_a_bits_source, auto_in_a_bits_address, auto_in_a_bits_mask,
           auto_in_a_bits_data,
    input  auto_in_a_ready,
    input  auto_out_a_valid, auto_out_a_bits_opcode, auto_out_a_bits_size,
           auto_out_a_bits_source, auto_out_a_bits_address, auto_out_a_bits_mask,
           auto_out_a_bits_data,
    output auto_out_a_ready,
    output auto_out_d_valid, auto_out_d_bits_opcode, auto_out_d_bits_size,
           auto_out_d_bits_source, auto_out_d_bits_denied, auto_out_d_bits_data,
           auto_out_d_bits_corrupt,
    input  auto_out_d_ready,
    input  auto_in_d_valid, auto_in_d_bits_opcode, auto_in_d_bits_size,
           auto_in_d_bits_source, auto_in_d_bits_denied, auto_in_d_bits_data,
           auto_in_d_bits_corrupt,
    output auto_in_d_ready
  );
endinterface

// File: rtl/tl_inflight_buffer.sv
// tl_inflight_buffer
//   Registered A and D queues between a TileLink client and the width widget,
//   plus per-source in-flight tracking with a sticky protocol error flag.
//   Ports:
//     clock         - sole clock, rising edge
//     reset         - asynchronous, active-low
//     bus           - A/D handshakes (tl_inflight_buffer_if.slave)
//     inflight_busy - bit s set while source s has a request outstanding
//     protocol_err  - sticky; duplicate A on a busy source or orphan D
module tl_inflight_buffer #(
  parameter int DEPTH_A = 2,
  parameter int DEPTH_D = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  tl_inflight_buffer_if.slave   bus,
  output logic [3:0]            inflight_busy,
  output logic                  protocol_err
);

  localparam int A_W  = 3 + 3 + 2 + 36 + 32 + 256;
  localparam int D_W  = 3 + 3 + 2 + 1 + 256 + 1;
  localparam int AP_W = $clog2(DEPTH_A);
  localparam int DP_W = $clog2(DEPTH_D);
  localparam int AC_W = AP_W + 1;
  localparam int DC_W = DP_W + 1;
  localparam logic [AC_W-1:0] A_FULL = AC_W'(DEPTH_A);
  localparam logic [DC_W-1:0] D_FULL = DC_W'(DEPTH_D);

  // ---------------- A queue ----------------
  logic [A_W-1:0]  mem_a [DEPTH_A];
  logic [AP_W-1:0] wr_ptr_a, rd_ptr_a;
  logic [AC_W-1:0] cnt_a;
  logic [A_W-1:0]  head_a;
  logic            a_in_ready, a_out_valid, a_enq, a_deq;

  // Ready depends only on the registered count, so a dequeue in a full cycle
  // opens the queue one cycle later. Gated by reset so it reads 0 in reset.
  assign a_in_ready  = (cnt_a != A_FULL) && reset;
  assign a_out_valid = (cnt_a != '0);
  assign a_enq       = bus.auto_in_a_valid && a_in_ready;
  assign a_deq       = a_out_valid && bus.auto_out_a_ready;
  assign head_a      = mem_a[rd_ptr_a];

  always_ff @(posedge clock) begin
    if (a_enq) begin
      mem_a[wr_ptr_a] <= {bus.auto_in_a_bits_opcode, bus.auto_in_a_bits_size,
                          bus.auto_in_a_bits_source, bus.auto_in_a_bits_address,
                          bus.auto_in_a_bits_mask, bus.auto_in_a_bits_data};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_a <= '0;
      rd_ptr_a <= '0;
      cnt_a    <= '0;
    end else begin
      if (a_enq) wr_ptr_a <= wr_ptr_a + 1'b1;
      if (a_deq) rd_ptr_a <= rd_ptr_a + 1'b1;
      case ({a_enq, a_deq})
        2'b10:   cnt_a <= cnt_a + 1'b1;
        2'b01:   cnt_a <= cnt_a - 1'b1;
        default: cnt_a <= cnt_a;
      endcase
    end
  end

  assign bus.auto_in_a_ready  = a_in_ready;
  assign bus.auto_out_a_valid = a_out_valid;
  assign {bus.auto_out_a_bits_opcode, bus.auto_out_a_bits_size,
          bus.auto_out_a_bits_source, bus.auto_out_a_bits_address,
          bus.auto_out_a_bits_mask, bus.auto_out_a_bits_data} = head_a;

  // ---------------- D queue ----------------
  logic [D_W-1:0]  mem_d [DEPTH_D];
  logic [DP_W-1:0] wr_ptr_d, rd_ptr_d;
  logic [DC_W-1:0] cnt_d;
  logic [D_W-1:0]  head_d;
  logic            d_in_ready, d_out_valid, d_enq, d_deq;

  assign d_in_ready  = (cnt_d != D_FULL) && reset;
  assign d_out_valid = (cnt_d != '0);
  assign d_enq       = bus.auto_out_d_valid && d_in_ready;
  assign d_deq       = d_out_valid && bus.auto_in_d_ready;
  assign head_d      = mem_d[rd_ptr_d];

  always_ff @(posedge clock) begin
    if (d_enq) begin
      mem_d[wr_ptr_d] <= {bus.auto_out_d_bits_opcode, bus.auto_out_d_bits_size,
                          bus.auto_out_d_bits_source, bus.auto_out_d_bits_denied,
                          bus.auto_out_d_bits_data, bus.auto_out_d_bits_corrupt};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_d <= '0;
      rd_ptr_d <= '0;
      cnt_d    <= '0;
    end else begin
      if (d_enq) wr_ptr_d <= wr_ptr_d + 1'b1;
      if (d_deq) rd_ptr_d <= rd_ptr_d + 1'b1;
      case ({d_enq, d_deq})
        2'b10:   cnt_d <= cnt_d + 1'b1;
        2'b01:   cnt_d <= cnt_d - 1'b1;
        default: cnt_d <= cnt_d;
      endcase
    end
  end

  assign bus.auto_out_d_ready = d_in_ready;
  assign bus.auto_in_d_valid  = d_out_valid;
  assign {bus.auto_in_d_bits_opcode, bus.auto_in_d_bits_size,
          bus.auto_in_d_bits_source, bus.auto_in_d_bits_denied,
          bus.auto_in_d_bits_data, bus.auto_in_d_bits_corrupt} = head_d;

  // ---------------- source tracking ----------------
  // Requests are tracked as they leave toward the widget and retired as the
  // response leaves upstream. Clear is applied before set so a same-cycle
  // retire/reissue of one source leaves it busy.
  logic [1:0] a_src, d_src;
  logic [3:0] set_mask, clr_mask, busy_next;
  logic       dup_a, orphan_d;

  assign a_src     = bus.auto_out_a_bits_source;
  assign d_src     = bus.auto_in_d_bits_source;
  assign set_mask  = a_deq ? (4'b0001 << a_src) : 4'b0000;
  assign clr_mask  = d_deq ? (4'b0001 << d_src) : 4'b0000;
  assign busy_next = (inflight_busy & ~clr_mask) | set_mask;
  assign dup_a     = a_deq && inflight_busy[a_src] && !clr_mask[a_src];
  assign orphan_d  = d_deq && !inflight_busy[d_src];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      inflight_busy <= '0;
      protocol_err  <= 1'b0;
    end else begin
      inflight_busy <= busy_next;
      if (dup_a || orphan_d) protocol_err <= 1'b1;
    end
  end

endmodule

// File: doc/tl_inflight_buffer.md
TL_INFLIGHT_BUFFER -- requirements
Module: tl_inflight_buffer

Interface
REQ-001 SHALL have parameter DEPTH_A, default 2, A-channel queue entries; legal values are powers of two >= 2.
REQ-002 SHALL have parameter DEPTH_D, default 2, D-channel queue entries; legal values are powers of two >= 2.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports auto_in_a_valid input 1 and auto_in_a_ready output 1, the upstream A handshake.
REQ-006 SHALL have ports auto_in_a_bits_{opcode 3, size 3, source 2, address 36, mask 32, data 256}, all inputs, the upstream A payload.
REQ-007 SHALL have ports auto_out_a_valid output 1 and auto_out_a_ready input 1, plus auto_out_a_bits_* outputs with the same widths as REQ-006; this is the downstream A channel toward the width widget.
REQ-008 SHALL have ports auto_out_d_valid input 1 and auto_out_d_ready output 1, plus auto_out_d_bits_{opcode 3, size 3, source 2, denied 1, data 256, corrupt 1}, all inputs.
REQ-009 SHALL have ports auto_in_d_valid output 1 and auto_in_d_ready input 1, plus auto_in_d_bits_* outputs with the same widths as REQ-008.
REQ-010 SHALL have port inflight_busy  output  4  one bit per source ID; the bit is 1 while that source has a request outstanding.
REQ-011 SHALL have port protocol_err  output  1  sticky flag that records a source-tracking violation.

Function
REQ-012 SHALL implement the A path as a DEPTH_A-entry FIFO: enqueue on auto_in_a_valid && auto_in_a_ready; dequeue on auto_out_a_valid && auto_out_a_ready.
REQ-013 SHALL drive auto_in_a_ready = (countA != DEPTH_A) && reset deasserted, with no combinational dependence on auto_out_a_ready.
REQ-014 SHALL drive auto_out_a_valid = (countA != 0) and present the head entry's payload, unmodified, on auto_out_a_bits_*.
REQ-015 SHALL give a minimum A latency of 1 cycle; an entry is never passed through in the same cycle it is enqueued.
REQ-016 SHALL, when the FIFO is full and a dequeue occurs, raise ready only in the following cycle.
REQ-017 SHALL, on simultaneous enqueue and dequeue while not full or empty, leave countA unchanged and advance both pointers.
REQ-018 SHALL wrap the read and write pointers modulo DEPTH_A.
REQ-019 SHALL implement the D path identically to REQ-012..REQ-018, using DEPTH_D: enqueue from auto_out_d_* and dequeue to auto_in_d_*.
REQ-020 SHALL preserve order within each channel and SHALL NOT drop, duplicate or reorder beats.
REQ-021 SHALL treat each A or D fire as exactly one beat, counting beats rather than messages.
REQ-022 SHALL set inflight_busy[s] on an auto_out_a fire with source s, and clear it on an auto_in_d fire with source s.
REQ-023 SHALL, when a set and a clear of the same source occur in the same cycle, leave the bit at 1 (the clear applies first, then the set).
REQ-024 SHALL set protocol_err on an auto_out_a fire whose source is already busy and not being cleared in that cycle.
REQ-025 SHALL set protocol_err on an auto_in_d fire whose source is not busy.
REQ-026 SHALL hold protocol_err at 1 until reset, and protocol_err SHALL NOT affect data flow.

Reset
REQ-027 SHALL, while reset is low, asynchronously clear countA, countD, all pointers, inflight_busy and protocol_err.
REQ-028 SHALL, while reset is low, drive auto_in_a_ready=0, auto_out_d_ready=0, auto_out_a_valid=0 and auto_in_d_valid=0.
REQ-029 SHALL, on reset assertion mid-transfer, discard all queued entries; the first cycle after deassertion presents both queues empty with both readies at 1.
REQ-030 SHALL leave FIFO data storage unreset, with its contents unobservable while the corresponding count is 0.

Verification
REQ-031 SHALL test single A beat: Get with source=1, address=0x8000_0040, with auto_out_a_ready=1 -> auto_out_a_valid=1 exactly one cycle later with identical bits, and inflight_busy=4'b0010.
REQ-032 SHALL test backpressure: auto_out_a_ready=0 while 3 beats are offered -> 2 accepted, auto_in_a_ready=0 from the cycle after the 2nd; releasing ready -> beats emerge in order, and the 3rd is accepted the cycle after the first dequeue.
REQ-033 SHALL test round trip: A fire source=2, then AccessAckData source=2 through D -> inflight_busy[2] sets then clears on the auto_in_d fire, and protocol_err stays 0.
REQ-034 SHALL test violations: a second A fire with source=3 while busy[3]=1 -> protocol_err=1 from the next cycle, held; an orphan D with source=0 gives the same result on a fresh run.
REQ-035 SHALL test same-cycle D fire with source=1 and A fire with source=1 -> busy[1] stays 1 and protocol_err stays 0.
REQ-036 SHALL test reset asserted with 2 A beats and 1 D beat queued -> all valids 0 immediately and busy=0; after deassertion no stale beat appears.
